exec_mdu: RTL
=============

Name: exec_mdu

Overview:
- Parametrised multi-cycle integer MUL/DIV unit (RV32M) in the Execute stage, beside the ALU.
- Receives already-forwarded operands from the Execute operand muxes.
- Holds the pipeline through `busy` while an operation is in flight, then returns the result and destination register for the LoadStore/writeback path.
- Generalises the single-cycle ALU: configurable width, configurable divider radix, flush support and a valid/ready issue handshake.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- RF_ADDR_W, 5, destination register address width.
- DIV_BITS, 1, quotient bits produced per divider iteration; legal values are 1 or 2, and XLEN % DIV_BITS == 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operation offered by Execute
- in_ready  out  1  unit can accept; high only in IDLE and when rst=0
- in_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_rs1  in  XLEN  forwarded operand A (dividend / multiplicand)
- in_rs2  in  XLEN  forwarded operand B (divisor / multiplier)
- in_rd  in  RF_ADDR_W  destination register
- flush  in  1  kill in-flight operation (branch/jump redirect)
- out_valid  out  1  one-cycle pulse, result valid
- out_result  out  XLEN  result, held until next completion
- out_rd  out  RF_ADDR_W  destination of out_result, held
- busy  out  1  high whenever state != IDLE; Execute stalls on it

Behaviour:
- Clock, reset and acceptance:
  - Single clock domain.
  - Reset is synchronous and active-high: when rst=1 at a posedge clk, the unit enters IDLE, and out_valid=0, out_result=0, out_rd=0, busy=0.
  - in_ready=0 while rst=1.
  - Accept occurs on a posedge with in_valid & in_ready; call this edge E0.
  - Operands, op and rd are captured at E0; input changes after E0 are ignored.
- State machine: IDLE, MUL, DIV_ITER, DIV_FIX, DONE.
  - IDLE: on accept of ops 0-3, go to MUL.
  - IDLE, fast-path divide: on accept of ops 4-7 with divisor==0 or a signed overflow case, go directly to DONE.
  - IDLE, normal divide: on any other accept of ops 4-7, go to DIV_ITER. This loads |rs1| and |rs2| for signed ops, records the result signs, sets iter_cnt = XLEN/DIV_BITS and clears the remainder.
  - MUL: the (XLEN+1)x(XLEN+1) signed product is registered, then go to DONE.
    - Operands are extended per op: MULH is signed x signed, MULHSU is signed x unsigned, MULHU and MUL zero-extend.
    - MUL returns the low XLEN bits; the other ops return the high XLEN bits.
  - DIV_ITER: each cycle performs DIV_BITS restoring shift-subtract steps and decrements iter_cnt. When iter_cnt reaches 1, go to DIV_FIX.
  - DIV_FIX: apply signs and select the result, then go to DONE.
    - The quotient is negated if the operand signs differ.
    - The remainder takes the sign of the dividend.
  - DONE: out_valid=1 for exactly one cycle, then go to IDLE. out_result and out_rd update on the edge entering DONE.
- Latency, with the cycle after E0 numbered 1 (out_valid high in the given cycle):
  - MUL ops: cycle 2.
  - Fast-path divide: cycle 1.
  - Normal divide: cycle XLEN/DIV_BITS + 2, i.e. 34 for 32/1 and 18 for 32/2.
- Special division results:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = -1, signed ops only): DIV gives the dividend; REM gives 0.
- Back-to-back issue:
  - in_ready is low in DONE, so the earliest next accept is the cycle after out_valid.
  - Maximum throughput is one MUL per 3 cycles.
- Flush:
  - flush=1 at a posedge from any state → IDLE, and no out_valid is produced for the killed operation.
  - out_result and out_rd keep their previous values.
  - flush together with in_valid in IDLE: the operation is NOT accepted.
  - flush in DONE: out_valid is already asserted in that cycle and is not retracted.
- Reset mid-operation: same as flush, and additionally clears out_result and out_rd.
- busy is combinational from state: it is 0 in IDLE and 1 in all other states, including DONE.

Decomposition:
- control_pkg:
  - e_mdu_op enum for the funct3 encodings.
  - e_mdu_state enum.
  - Constants MDU_OP_MUL..MDU_OP_REMU.
- Sub-module mdu_div_core:
  - Iterative unsigned restoring divider.
  - Parametrised by XLEN and DIV_BITS.
  - Interface: start/load, step enable, quotient and remainder outputs.
- exec_mdu keeps the FSM, the multiplier, the sign handling and the special-case detection.

Test Plan:
- MULH, rs1=0x80000000, rs2=0x80000000 → out_valid in cycle 2, out_result=0x40000000. MULHU with rs1=rs2=0xFFFFFFFF → 0xFFFFFFFE.
- DIV, rs1=-7 (0xFFFFFFF9), rs2=2, DIV_BITS=1 → out_valid in cycle 34, out_result=0xFFFFFFFD (-3). REM on the same operands → 0xFFFFFFFF (-1).
- DIVU, rs2=0, rs1=0x1234 → out_valid in cycle 1, out_result=0xFFFFFFFF. REMU on the same operands → 0x1234.
- DIV, rs1=0x80000000, rs2=0xFFFFFFFF → out_valid in cycle 1, out_result=0x80000000. REM on the same operands → 0.
- Start DIVU 100/7, assert flush in cycle 10 → busy=0 in cycle 11, no out_valid, out_result keeps its prior value. A following MUL 6*7 → out_result=42.
- Assert rst in cycle 5 of a DIV → cycle 6 shows busy=0, out_result=0, out_rd=0, in_ready=1. With DIV_BITS=2, DIVU 0xFFFFFFFF/3 → 0x55555555 in cycle 18.

Source files
------------

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared MUL/DIV opcode and state encodings
package control_pkg;

    // funct3 encodings of the RV32M operations
    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } e_mdu_op;

    typedef enum logic [2:0] {
        MDU_ST_IDLE     = 3'd0,
        MDU_ST_MUL      = 3'd1,
        MDU_ST_DIV_ITER = 3'd2,
        MDU_ST_DIV_FIX  = 3'd3,
        MDU_ST_DONE     = 3'd4
    } e_mdu_state;

    localparam logic [2:0] MDU_OP_MUL    = MDU_MUL;
    localparam logic [2:0] MDU_OP_MULH   = MDU_MULH;
    localparam logic [2:0] MDU_OP_MULHSU = MDU_MULHSU;
    localparam logic [2:0] MDU_OP_MULHU  = MDU_MULHU;
    localparam logic [2:0] MDU_OP_DIV    = MDU_DIV;
    localparam logic [2:0] MDU_OP_DIVU   = MDU_DIVU;
    localparam logic [2:0] MDU_OP_REM    = MDU_REM;
    localparam logic [2:0] MDU_OP_REMU   = MDU_REMU;

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - iterative unsigned restoring divider, DIV_BITS quotient bits per step
module mdu_div_core #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;   // holds the unshifted dividend bits, then the quotient
    logic [XLEN-1:0] div_q;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN:0]   trial;

    // DIV_BITS chained restoring steps: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_nxt = rem_q;
        quo_nxt = quo_q;
        trial   = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            trial   = {rem_nxt, quo_nxt[XLEN-1]};
            quo_nxt = {quo_nxt[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, div_q}) begin
                trial      = trial - {1'b0, div_q};
                quo_nxt[0] = 1'b1;
            end
            rem_nxt = trial[XLEN-1:0];
        end
    end

    // operand load on start, one iteration per enabled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
        end else if (step) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/exec_mdu.sv
// rtl/exec_mdu.sv - multi-cycle RV32M multiply/divide unit for the Execute stage
module exec_mdu
    import control_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5,
    parameter int DIV_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [RF_ADDR_W-1:0] in_rd,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [XLEN-1:0]      out_result,
    output logic [RF_ADDR_W-1:0] out_rd,
    output logic                 busy
);

    localparam int ITERS = XLEN / DIV_BITS;
    localparam int CNT_W = $clog2(ITERS + 1);

    localparam logic [2:0] ST_IDLE     = MDU_ST_IDLE;
    localparam logic [2:0] ST_MUL      = MDU_ST_MUL;
    localparam logic [2:0] ST_DIV_ITER = MDU_ST_DIV_ITER;
    localparam logic [2:0] ST_DIV_FIX  = MDU_ST_DIV_FIX;
    localparam logic [2:0] ST_DONE     = MDU_ST_DONE;

    logic [2:0]           state;
    logic [2:0]           op_q;
    logic [RF_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]      a_q;
    logic [XLEN-1:0]      b_q;
    logic                 neg_quo;
    logic                 neg_rem;
    logic [CNT_W-1:0]     iter_cnt;

    logic                 accept;
    logic                 signed_in;
    logic                 div_zero;
    logic                 div_ovf;
    logic                 div_load;
    logic [XLEN-1:0]      fast_res;
    logic [XLEN-1:0]      a_abs;
    logic [XLEN-1:0]      b_abs;

    logic                 mul_a_sgn;
    logic                 mul_b_sgn;
    logic signed [2*XLEN-1:0] mul_a;
    logic signed [2*XLEN-1:0] mul_b;
    logic signed [2*XLEN-1:0] prod;
    logic [XLEN-1:0]      mul_res;

    logic [XLEN-1:0]      div_quo;
    logic [XLEN-1:0]      div_rem;
    logic [XLEN-1:0]      quo_s;
    logic [XLEN-1:0]      rem_s;
    logic [XLEN-1:0]      fix_res;

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // issue-side decode: special divide cases and operand magnitudes
    always_comb begin
        accept    = in_valid && in_ready && !flush;
        signed_in = !in_op[0];
        div_zero  = (in_rs2 == '0);
        div_ovf   = signed_in && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
        if (div_zero)
            fast_res = in_op[1] ? in_rs1 : '1;
        else
            fast_res = in_op[1] ? '0 : in_rs1;
        a_abs    = (signed_in && in_rs1[XLEN-1]) ? (~in_rs1 + 1'b1) : in_rs1;
        b_abs    = (signed_in && in_rs2[XLEN-1]) ? (~in_rs2 + 1'b1) : in_rs2;
        div_load = accept && in_op[2] && !div_zero && !div_ovf;
    end

    // multiplier on captured operands, extended per op before the full-width product
    always_comb begin
        mul_a_sgn = ((op_q == MDU_OP_MULH) || (op_q == MDU_OP_MULHSU)) && a_q[XLEN-1];
        mul_b_sgn = (op_q == MDU_OP_MULH) && b_q[XLEN-1];
        mul_a     = {{XLEN{mul_a_sgn}}, a_q};
        mul_b     = {{XLEN{mul_b_sgn}}, b_q};
        prod      = mul_a * mul_b;
        mul_res   = (op_q == MDU_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // sign restoration of the unsigned divider outputs
    always_comb begin
        quo_s   = neg_quo ? (~div_quo + 1'b1) : div_quo;
        rem_s   = neg_rem ? (~div_rem + 1'b1) : div_rem;
        fix_res = op_q[1] ? rem_s : quo_s;
    end

    mdu_div_core #(
        .XLEN     (XLEN),
        .DIV_BITS (DIV_BITS)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (state == ST_DIV_ITER),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // control FSM; result registers only move on the edge entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
            iter_cnt   <= '0;
            out_result <= '0;
            out_rd     <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= in_op;
                        rd_q <= in_rd;
                        a_q  <= in_rs1;
                        b_q  <= in_rs2;
                        if (!in_op[2]) begin
                            state <= ST_MUL;
                        end else if (div_zero || div_ovf) begin
                            out_result <= fast_res;
                            out_rd     <= in_rd;
                            state      <= ST_DONE;
                        end else begin
                            neg_quo  <= signed_in && (in_rs1[XLEN-1] ^ in_rs2[XLEN-1]);
                            neg_rem  <= signed_in && in_rs1[XLEN-1];
                            iter_cnt <= CNT_W'(ITERS);
                            state    <= ST_DIV_ITER;
                        end
                    end
                end
                ST_MUL: begin
                    out_result <= mul_res;
                    out_rd     <= rd_q;
                    state      <= ST_DONE;
                end
                ST_DIV_ITER: begin
                    iter_cnt <= iter_cnt - 1'b1;
                    if (iter_cnt == CNT_W'(1))
                        state <= ST_DIV_FIX;
                end
                ST_DIV_FIX: begin
                    out_result <= fix_res;
                    out_rd     <= rd_q;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
